// File: rtl/daq_rate_switch_fsm.sv
// daq_rate_switch_fsm: table-driven line-rate switch sequencer with hold counters and timeout/retry supervision
module daq_rate_switch_fsm #(
  parameter int NUM_RATES = 2,
  parameter int RESET_RATE = 1,
  parameter logic [3*NUM_RATES-1:0] CLK_SEL_TABLE = 6'b001_000,
  parameter logic [2*NUM_RATES-1:0] RATE_SEL_TABLE = 4'b11_10,
  parameter logic [NUM_RATES-1:0] WRDCLK_TABLE = 2'b10,
  parameter int WRDCLK_HOLD = 4,
  parameter int PCSRST_CYCLES = 4,
  parameter int TIMEOUT = 1023,
  parameter int MAX_RETRY = 2,
  localparam int RW = (NUM_RATES > 2) ? $clog2(NUM_RATES) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [RW-1:0] RATE_REQ,
  input  logic          CLR_FAULT,
  input  logic          TXRATEDONE,
  input  logic          CDV_DONE,
  output logic [2:0]    CLK_SEL,
  output logic [1:0]    RATE_SEL,
  output logic          WRDCLKSEL,
  output logic          CDV_INIT,
  output logic          PCSRST,
  output logic [RW-1:0] CUR_RATE,
  output logic          LOCKED,
  output logic          FAULT,
  output logic [2:0]    RETRY_CNT,
  output logic [2:0]    STATE
);
  typedef enum logic [2:0] {
    S_LOCKED = 3'd0, S_REFCLK = 3'd1, S_WRDCLK = 3'd2,
    S_RSTCDV = 3'd3, S_RSTPCS = 3'd4, S_FAULT = 3'd5
  } state_t;
  localparam logic [RW-1:0] RST_RATE = RW'(RESET_RATE);
  state_t st, nxt;
  logic [RW-1:0] req_q, tgt, nxt_tgt, nxt_cur, sel;
  logic [15:0] cnt;
  logic [2:0] nxt_retry;
  logic req_ok, restart, can_retry;
  assign req_ok = 32'(req_q) < NUM_RATES;
  assign can_retry = RETRY_CNT < 3'(MAX_RETRY);
  assign STATE = st;
  // REFCLK and RSTCDV share the wait/timeout path; only the awaited done input differs
  always_comb begin
    nxt = st;
    nxt_tgt = tgt;
    nxt_cur = CUR_RATE;
    nxt_retry = RETRY_CNT;
    restart = 1'b0;
    case (st)
      S_LOCKED: if (req_ok && req_q != CUR_RATE) begin
        nxt = S_REFCLK;
        nxt_tgt = req_q;
        nxt_retry = '0;
      end
      S_REFCLK, S_RSTCDV:
        if (st == S_REFCLK ? TXRATEDONE : CDV_DONE) nxt = (st == S_REFCLK) ? S_WRDCLK : S_RSTPCS;
        else if (cnt == 16'(TIMEOUT)) begin
          restart = 1'b1;
          nxt = can_retry ? S_REFCLK : S_FAULT;
          nxt_retry = can_retry ? RETRY_CNT + 3'd1 : RETRY_CNT;
        end
      S_WRDCLK: if (cnt == 16'(WRDCLK_HOLD - 1)) nxt = S_RSTCDV;
      S_RSTPCS: if (cnt == 16'(PCSRST_CYCLES - 1)) begin
        nxt = S_LOCKED;
        nxt_cur = tgt;
      end
      S_FAULT: if (CLR_FAULT || (req_ok && req_q != tgt)) begin
        nxt = S_REFCLK;
        nxt_retry = '0;
        nxt_tgt = CLR_FAULT ? tgt : req_q;
      end
      default: nxt = S_LOCKED;
    endcase
  end
  // Outputs are decoded from the next state so they line up with the state's first cycle
  assign sel = (nxt == S_LOCKED) ? nxt_cur : nxt_tgt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= S_LOCKED;
      req_q <= RST_RATE;
      tgt <= RST_RATE;
      CUR_RATE <= RST_RATE;
      RETRY_CNT <= '0;
      cnt <= '0;
      CLK_SEL <= CLK_SEL_TABLE[3*RESET_RATE +: 3];
      RATE_SEL <= RATE_SEL_TABLE[2*RESET_RATE +: 2];
      WRDCLKSEL <= WRDCLK_TABLE[RESET_RATE];
      CDV_INIT <= 1'b1;
      PCSRST <= 1'b0;
      LOCKED <= 1'b1;
      FAULT <= 1'b0;
    end else begin
      st <= nxt;
      req_q <= RATE_REQ;
      tgt <= nxt_tgt;
      CUR_RATE <= nxt_cur;
      RETRY_CNT <= nxt_retry;
      cnt <= (nxt != st || restart) ? '0 : cnt + 16'd1;
      CLK_SEL <= CLK_SEL_TABLE[3*sel +: 3];
      RATE_SEL <= RATE_SEL_TABLE[2*sel +: 2];
      WRDCLKSEL <= (nxt != S_REFCLK) && WRDCLK_TABLE[sel];
      CDV_INIT <= nxt inside {S_REFCLK, S_WRDCLK};
      PCSRST <= nxt == S_RSTPCS;
      LOCKED <= nxt == S_LOCKED;
      FAULT <= nxt == S_FAULT;
    end
endmodule

// File: tb/tb_daq_rate_switch_fsm.sv
// tb_daq_rate_switch_fsm: directed stimulus, per-cycle reference model compare, and hand-computed pins
module tb_daq_rate_switch_fsm;
  localparam int NR = 3, RR = 1, HOLD = 4, PCS = 4, TO = 15, MR = 2;
  logic CLK = 1'b0, RST_N = 1'b0, CLR_FAULT = 1'b0, TXRATEDONE = 1'b0, CDV_DONE = 1'b0;
  logic [1:0] RATE_REQ = 2'd1;
  logic [2:0] CLK_SEL, RETRY_CNT, STATE;
  logic [1:0] RATE_SEL, CUR_RATE;
  logic WRDCLKSEL, CDV_INIT, PCSRST, LOCKED, FAULT;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int tx_mode = 2, cdv_mode = 2;
  logic [2:0] t_clk [3] = '{3'b000, 3'b001, 3'b010};
  logic [1:0] t_rate [3] = '{2'b10, 2'b11, 2'b01};
  logic t_wrd [3] = '{1'b0, 1'b1, 1'b0};
  int m_st, m_tgt, m_cur, m_req, m_retry, m_n;
  bit m_fresh;

  daq_rate_switch_fsm #(
    .NUM_RATES(NR), .RESET_RATE(RR),
    .CLK_SEL_TABLE(9'b010_001_000), .RATE_SEL_TABLE(6'b01_11_10), .WRDCLK_TABLE(3'b010),
    .WRDCLK_HOLD(HOLD), .PCSRST_CYCLES(PCS), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .RATE_REQ(RATE_REQ), .CLR_FAULT(CLR_FAULT),
    .TXRATEDONE(TXRATEDONE), .CDV_DONE(CDV_DONE), .CLK_SEL(CLK_SEL), .RATE_SEL(RATE_SEL),
    .WRDCLKSEL(WRDCLKSEL), .CDV_INIT(CDV_INIT), .PCSRST(PCSRST), .CUR_RATE(CUR_RATE),
    .LOCKED(LOCKED), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_n is the number of cycles already spent in the current phase
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_st <= 0; m_tgt <= RR; m_cur <= RR; m_req <= RR; m_retry <= 0; m_n <= 0; m_fresh <= 1;
    end else begin
      m_fresh <= 0;
      m_req <= RATE_REQ;
      m_n <= m_n + 1;
      if (m_st == 0) begin
        if (m_req < NR && m_req != m_cur) begin
          m_st <= 1; m_n <= 0; m_tgt <= m_req; m_retry <= 0;
        end
      end else if (m_st == 1 || m_st == 3) begin
        if ((m_st == 1) ? TXRATEDONE : CDV_DONE) begin
          m_st <= (m_st == 1) ? 2 : 4; m_n <= 0;
        end else if (m_n == TO) begin
          m_n <= 0;
          if (m_retry < MR) begin m_retry <= m_retry + 1; m_st <= 1; end
          else m_st <= 5;
        end
      end else if (m_st == 2) begin
        if (m_n == HOLD - 1) begin m_st <= 3; m_n <= 0; end
      end else if (m_st == 4) begin
        if (m_n == PCS - 1) begin m_st <= 0; m_n <= 0; m_cur <= m_tgt; end
      end else if (CLR_FAULT) begin
        m_st <= 1; m_n <= 0; m_retry <= 0;
      end else if (m_req < NR && m_req != m_tgt) begin
        m_st <= 1; m_n <= 0; m_tgt <= m_req; m_retry <= 0;
      end
    end
  end

  // Handshake responder: mode 0 never answers, 1 holds high, 2 answers in the 4th cycle of the wait
  initial forever begin
    @(negedge CLK);
    TXRATEDONE = tx_mode == 1 || (tx_mode == 2 && m_st == 1 && m_n >= 3);
    CDV_DONE = cdv_mode == 1 || (cdv_mode == 2 && m_st == 3 && m_n >= 3);
  end

  initial forever begin : cmp
    int s;
    @(negedge CLK);
    if (chk_en) begin
      s = (m_st == 0) ? m_cur : m_tgt;
      chk("state", STATE, m_st);
      chk("clk_sel", CLK_SEL, t_clk[s]);
      chk("rate_sel", RATE_SEL, t_rate[s]);
      chk("wrdclksel", WRDCLKSEL, (m_st == 1) ? 1'b0 : t_wrd[s]);
      chk("cdv_init", CDV_INIT, m_fresh || m_st == 1 || m_st == 2);
      chk("pcsrst", PCSRST, m_st == 4);
      chk("locked", LOCKED, m_st == 0);
      chk("fault", FAULT, m_st == 5);
      chk("cur_rate", CUR_RATE, m_cur);
      chk("retry_cnt", RETRY_CNT, m_retry);
    end
  end

  task automatic run_switch(input int budget, output int first_ref, output int n_ref, output int n_wrd,
                            output int n_cdv, output int n_pcs, output logic ref_wrd, output bit done);
    bit busy;
    busy = 0; first_ref = 0; n_ref = 0; n_wrd = 0; n_cdv = 0; n_pcs = 0; ref_wrd = 0; done = 0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(negedge CLK);
      if (STATE == 3'd1) begin
        n_ref++;
        ref_wrd |= WRDCLKSEL;
        if (first_ref == 0) first_ref = i;
      end
      if (STATE == 3'd2) n_wrd++;
      if (STATE == 3'd3) n_cdv++;
      if (PCSRST) n_pcs++;
      if (STATE != 3'd0) busy = 1;
      done = busy && LOCKED;
    end
  endtask

  initial begin : main
    int fr, nr, nw, nc, np, t0, t1, t2, tf;
    logic rw;
    bit dn, ok, all_l;
    repeat (3) @(negedge CLK);
    chk("rst_clk_sel", CLK_SEL, 3'b001);
    chk("rst_rate_sel", RATE_SEL, 2'b11);
    chk("rst_wrdclksel", WRDCLKSEL, 1);
    chk("rst_cdv_init", CDV_INIT, 1);
    chk("rst_locked", LOCKED, 1);
    chk("rst_pcsrst", PCSRST, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_retry", RETRY_CNT, 0);
    chk("rst_cur_rate", CUR_RATE, 1);
    chk("rst_state", STATE, 0);
    RST_N = 1;
    chk_en = 1;
    @(negedge CLK);
    chk("cdv_init_drop", CDV_INIT, 0);

    RATE_REQ = 2'd0;
    run_switch(80, fr, nr, nw, nc, np, rw, dn);
    chk("sw0_done", dn, 1);
    chk("sw0_latency", fr, 2);
    chk("sw0_refclk_cycles", nr, 4);
    chk("sw0_wrdclk_cycles", nw, 4);
    chk("sw0_rstcdv_cycles", nc, 4);
    chk("sw0_pcsrst_width", np, 4);
    chk("sw0_clk_sel", CLK_SEL, 3'b000);
    chk("sw0_rate_sel", RATE_SEL, 2'b10);
    chk("sw0_wrdclksel", WRDCLKSEL, 0);
    chk("sw0_cur_rate", CUR_RATE, 0);

    RATE_REQ = 2'd1;
    run_switch(80, fr, nr, nw, nc, np, rw, dn);
    chk("sw1_done", dn, 1);
    chk("sw1_latency", fr, 2);
    chk("sw1_wrd_low_in_refclk", rw, 0);
    chk("sw1_pcsrst_width", np, 4);
    chk("sw1_clk_sel", CLK_SEL, 3'b001);
    chk("sw1_rate_sel", RATE_SEL, 2'b11);
    chk("sw1_wrdclksel", WRDCLKSEL, 1);
    chk("sw1_cur_rate", CUR_RATE, 1);

    tx_mode = 0;
    RATE_REQ = 2'd0;
    t0 = 0; t1 = 0; t2 = 0; tf = 0;
    for (int i = 1; i <= 120 && tf == 0; i++) begin
      @(negedge CLK);
      if (t0 == 0 && STATE == 3'd1) t0 = i;
      if (t1 == 0 && RETRY_CNT == 3'd1) t1 = i;
      if (t2 == 0 && RETRY_CNT == 3'd2) t2 = i;
      if (FAULT) tf = i;
    end
    chk("to_first_refclk", t0, 2);
    chk("to_retry1", t1, 18);
    chk("to_retry2", t2, 34);
    chk("to_fault", tf, 50);
    chk("to_fault_state", STATE, 5);
    chk("to_fault_retry", RETRY_CNT, 2);
    tx_mode = 1;
    @(negedge CLK);
    CLR_FAULT = 1;
    @(negedge CLK);
    CLR_FAULT = 0;
    chk("clr_state", STATE, 1);
    chk("clr_retry", RETRY_CNT, 0);
    run_switch(60, fr, nr, nw, nc, np, rw, dn);
    chk("clr_done", dn, 1);
    chk("clr_wrdclk_cycles", nw, 4);
    chk("clr_cur_rate", CUR_RATE, 0);
    tx_mode = 2;

    RATE_REQ = 2'd1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge CLK); ok = STATE == 3'd2; end
    chk("tog_reach_wrdclk", ok, 1);
    RATE_REQ = 2'd0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge CLK); ok = LOCKED; end
    chk("tog_locked", ok, 1);
    chk("tog_cur_rate1", CUR_RATE, 1);
    @(negedge CLK);
    chk("tog_locked_one_cycle", LOCKED, 0);
    chk("tog_restart_state", STATE, 1);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge CLK); ok = LOCKED; end
    chk("tog_relocked", ok, 1);
    chk("tog_cur_rate0", CUR_RATE, 0);

    RATE_REQ = 2'd3;
    all_l = 1;
    repeat (10) begin @(negedge CLK); all_l &= LOCKED && STATE == 3'd0; end
    chk("invalid_ignored", all_l, 1);
    chk("invalid_cur_rate", CUR_RATE, 0);

    RATE_REQ = 2'd2;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge CLK); ok = PCSRST; end
    chk("arst_reach_pcs", ok, 1);
    chk("arst_pre_clk_sel", CLK_SEL, 3'b010);
    #2 RST_N = 0;
    #1;
    chk("arst_pcsrst", PCSRST, 0);
    chk("arst_clk_sel", CLK_SEL, 3'b001);
    chk("arst_rate_sel", RATE_SEL, 2'b11);
    chk("arst_wrdclksel", WRDCLKSEL, 1);
    chk("arst_cdv_init", CDV_INIT, 1);
    chk("arst_locked", LOCKED, 1);
    chk("arst_state", STATE, 0);
    chk("arst_cur_rate", CUR_RATE, 1);
    RATE_REQ = 2'd1;
    repeat (2) @(negedge CLK);
    RST_N = 1;
    repeat (3) @(negedge CLK);
    chk("post_rst_locked", LOCKED, 1);
    chk("post_rst_cur_rate", CUR_RATE, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/daq_rate_switch_fsm.md
# daq_rate_switch_fsm

Parametrised line-rate switch sequencer for the DAQ optical output path. It supports up to 8 rates described by parameter tables, with internal hold counters and timeout/retry supervision of the transceiver handshakes. It sits between the rate-request register and the GTX/clock-divider controls, and it replaces the fixed two-rate sequencer with its external count input.

## Interface
- NUM_RATES, 2: number of supported rates (2..8); RW = max(1, clog2(NUM_RATES)).
- RESET_RATE, 1: rate index loaded at reset.
- CLK_SEL_TABLE, 6'b001_000: 3 bits per rate; entry i is [3i+2:3i].
- RATE_SEL_TABLE, 4'b11_10: 2 bits per rate; entry i is [2i+1:2i].
- WRDCLK_TABLE, 2'b10: 1 bit per rate, giving the WRDCLKSEL value for rate i.
- WRDCLK_HOLD, 4: cycles spent in WRDCLK (range 1..255).
- PCSRST_CYCLES, 4: width of the PCSRST pulse in cycles (range 1..255).
- TIMEOUT, 1023: cycle limit for waiting on TXRATEDONE or CDV_DONE (range 1..65535).
- MAX_RETRY, 2: number of timeout retries allowed before FAULT (range 0..7).

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: reset, asynchronous and active-low.
- RATE_REQ, in, RW: requested rate index (level).
- CLR_FAULT, in, 1: single-cycle pulse that retries from FAULT.
- TXRATEDONE, in, 1: transceiver rate-change done.
- CDV_DONE, in, 1: clock-divider reset done.
- CLK_SEL, out, 3: reference-clock select.
- RATE_SEL, out, 2: GTX TXRATE.
- WRDCLKSEL, out, 1: word-clock select.
- CDV_INIT, out, 1: clock-divider init.
- PCSRST, out, 1: PCS reset.
- CUR_RATE, out, RW: rate index currently locked.
- LOCKED, out, 1: steady at CUR_RATE.
- FAULT, out, 1: retries exhausted.
- RETRY_CNT, out, 3: number of retries in the current switch.
- STATE, out, 3: state code for debug.

## Operation
States and their codes:
- LOCKED = 0
- REFCLK = 1
- WRDCLK = 2
- RSTCDV = 3
- RSTPCS = 4
- FAULT = 5

Terms:
- TGT is the target-rate register.
- A request is valid if RATE_REQ < NUM_RATES. Invalid requests are ignored.

Transitions:
- LOCKED: if the request is valid and differs from CUR_RATE, latch TGT = RATE_REQ, clear RETRY_CNT, go to REFCLK.
- REFCLK: on TXRATEDONE go to WRDCLK.
- WRDCLK: after exactly WRDCLK_HOLD cycles go to RSTCDV.
- RSTCDV: on CDV_DONE go to RSTPCS.
- RSTPCS: after exactly PCSRST_CYCLES cycles, set CUR_RATE = TGT and go to LOCKED.
- Timeout: in REFCLK or RSTCDV, when the wait counter reaches TIMEOUT without the awaited input:
  - if RETRY_CNT < MAX_RETRY, increment RETRY_CNT and go to REFCLK;
  - otherwise go to FAULT.
- FAULT:
  - on CLR_FAULT, clear RETRY_CNT and go to REFCLK with the same TGT;
  - otherwise, on a valid RATE_REQ different from TGT, latch the new TGT, clear RETRY_CNT and go to REFCLK.
  - CLR_FAULT has priority if both occur.
- RATE_REQ changes while mid-sequence (REFCLK..RSTPCS) are ignored. The sequence completes, and LOCKED re-evaluates the request one cycle after entry.
- One internal 16-bit counter serves all states. It clears on every state entry, including re-entry to REFCLK on retry.

Outputs are registered and decoded from nextstate, so they are valid in the first cycle of the state:
- LOCKED: CLK_SEL, RATE_SEL and WRDCLKSEL = table[CUR_RATE]; LOCKED = 1.
- REFCLK: CLK_SEL and RATE_SEL = table[TGT]; WRDCLKSEL = 0; CDV_INIT = 1.
- WRDCLK: CLK_SEL, RATE_SEL and WRDCLKSEL = table[TGT]; CDV_INIT = 1.
- RSTCDV: CLK_SEL, RATE_SEL and WRDCLKSEL = table[TGT].
- RSTPCS: CLK_SEL, RATE_SEL and WRDCLKSEL = table[TGT]; PCSRST = 1.
- FAULT: CLK_SEL, RATE_SEL and WRDCLKSEL = table[TGT]; FAULT = 1.
- CDV_INIT, PCSRST, LOCKED and FAULT are 0 in all other states.

## Timing
- Reset (RST_N = 0) values:
  - state = LOCKED; CUR_RATE = TGT = RESET_RATE.
  - CLK_SEL, RATE_SEL and WRDCLKSEL = table[RESET_RATE].
  - CDV_INIT = 1; LOCKED = 1; PCSRST = 0; FAULT = 0; RETRY_CNT = 0.
- CDV_INIT drops on the first clock after reset release.
- Reset asserted mid-sequence aborts immediately to the reset values. No PCSRST pulse is completed.
- Request to first REFCLK cycle: 2 CLK edges (RATE_REQ sample, then registered output).
- PCSRST is high for exactly PCSRST_CYCLES consecutive cycles.
- WRDCLK lasts exactly WRDCLK_HOLD cycles.
- A done input already high in the entry cycle of its wait state is honoured in that cycle. The state occupancy is then 1 cycle.
- A done input arriving in the same cycle as the timeout takes priority over the timeout.
- Minimum switch time with done inputs tied high: 1 + WRDCLK_HOLD + 1 + PCSRST_CYCLES cycles from REFCLK entry to LOCKED.

## Test plan
- Reset, then RATE_REQ = 0, with TXRATEDONE and CDV_DONE returned 3 cycles after each request → the sequence REFCLK, WRDCLK ×4, RSTCDV, RSTPCS ×4, LOCKED. Required response: CLK_SEL = 000, RATE_SEL = 10, WRDCLKSEL = 0, CUR_RATE = 0.
- From rate 0, RATE_REQ = 1 → WRDCLKSEL = 0 during REFCLK, then 1. Ends with CLK_SEL = 001, RATE_SEL = 11, CUR_RATE = 1, PCSRST pulse of exactly 4 cycles.
- TXRATEDONE held low, TIMEOUT = 15, MAX_RETRY = 2 → two REFCLK re-entries 16 cycles apart, RETRY_CNT goes 1 then 2, then FAULT = 1 and STATE = 5. Then pulse CLR_FAULT with TXRATEDONE high → sequence completes and LOCKED = 1.
- RATE_REQ toggles 0→1→0 during WRDCLK → the switch to 1 completes. LOCKED is 1 for one cycle, then a new switch to 0 starts.
- NUM_RATES = 3, RATE_REQ = 3 (invalid) → no state change and LOCKED stays 1.
- Drop RST_N during RSTPCS → PCSRST = 0 and outputs = table[RESET_RATE] immediately, asynchronously.
